mainfsm: RTL and testbench

Main control state machine of the multicycle ARM controller. It sequences each instruction through fetch, decode, execute and writeback. Its unconditioned write requests (NextPC, Branch, RegW, MemW) feed the condition logic stage, which gates them with the registered condition result. Its datapath selects drive the multiplexers, ALU and instruction register directly.

---
 rtl/mainfsm.sv | 188 ++++++++++++++++++
 tb/tb_mainfsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mainfsm.sv
// mainfsm: main control state machine of the multicycle ARM controller.
// Sequences each instruction through fetch, decode, execute and writeback.
// All outputs are Moore: they depend on the current state only. The write
// requests (NextPC, RegW, MemW, Branch) are unconditioned here. Downstream
// condition logic gates them with the registered condition result.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State,
  output logic       Illegal
);

  // State encoding is fixed because State is exported for trace tools.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  // Instruction class, taken from Op[1:0] = instr[27:26].
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Datapath select codes.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // One control word per state. Building it as a struct keeps each state's
  // entry to the signals that differ from zero.
  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       illegal;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // Funct[4:1] carry the data-processing opcode and the memory P/U/B/W bits.
  // Those are decoded elsewhere. Only I (bit 5) and L (bit 0) steer this FSM.
  logic funct_unused;
  assign funct_unused = ^Funct[4:1];

  // State register with a synchronous reset back to FETCH.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values. Blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Op and Funct only matter in DECODE and MEMADR.
  // NOTE: state_d gets a default before the case, so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN: state_d = FETCH;
      // Codes 11-15 cannot be reached. If one ever appears, restart the
      // instruction sequence.
      default:  state_d = FETCH;
    endcase
  end

  // Moore output decode. Any signal a state does not drive stays 0.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
        ctrl.adr_src    = 1'b0;
      end
      // Computes PC+8, which the register file exposes as R15.
      DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURES;
      end
      EXECUTER: begin
        ctrl.alu_op    = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
      end
      EXECUTEI: begin
        ctrl.alu_op    = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ALUWB: begin
        ctrl.reg_w      = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      MEMADR: begin
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl.adr_src = 1'b1;
      end
      MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_w      = 1'b1;
        ctrl.result_src = RES_DATA;
      end
      BRANCH: begin
        ctrl.branch     = 1'b1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALURES;
      end
      UNKNOWN: begin
        ctrl.illegal = 1'b1;
      end
      // Unreachable codes behave like UNKNOWN, so no write can escape.
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.alu_op;
  assign Illegal   = ctrl.illegal;
  assign State     = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: directed bench for mainfsm. It checks the full output word
// against hand-written per-state constants, step by step through each
// instruction class, including reset hold and mid-instruction reset.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [3:0] State;
  logic       Illegal;

  int checks   = 0;
  int failures = 0;

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .State     (State),
    .Illegal   (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
  //               NextPC, RegW, MemW, Branch, ALUOp, Illegal}
  localparam logic [16:0] W_FETCH    = {4'd0,  1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] W_DECODE   = {4'd1,  1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] W_MEMADR   = {4'd2,  1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] W_MEMRD    = {4'd3,  1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] W_MEMWB    = {4'd4,  1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] W_MEMWR    = {4'd5,  1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] W_EXECUTER = {4'd6,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [16:0] W_EXECUTEI = {4'd7,  1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [16:0] W_ALUWB    = {4'd8,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [16:0] W_BRANCH   = {4'd9,  1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [16:0] W_UNKNOWN  = {4'd10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  function automatic logic [16:0] exp_word(input logic [3:0] s);
    case (s)
      4'd0:    return W_FETCH;
      4'd1:    return W_DECODE;
      4'd2:    return W_MEMADR;
      4'd3:    return W_MEMRD;
      4'd4:    return W_MEMWB;
      4'd5:    return W_MEMWR;
      4'd6:    return W_EXECUTER;
      4'd7:    return W_EXECUTEI;
      4'd8:    return W_ALUWB;
      4'd9:    return W_BRANCH;
      default: return W_UNKNOWN;
    endcase
  endfunction

  function automatic logic [16:0] obs_word();
    return {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            NextPC, RegW, MemW, Branch, ALUOp, Illegal};
  endfunction

  task automatic check(input string tag, input logic [16:0] observed,
                       input logic [16:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starting in FETCH, apply one instruction and check each state in turn.
  // seq holds the expected state codes, with the first one in the low nibble.
  // The last code is the FETCH that starts the next instruction.
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] funct, input logic [23:0] seq,
                           input int len);
    Op    = op;
    Funct = funct;
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_cyc%0d", name, i), obs_word(), exp_word(seq[4*i +: 4]));
      if (i < len - 1) step();
    end
  endtask

  initial begin
    reset = 1'b1;
    Op    = 2'b11;
    Funct = 6'b000000;

    // Reset hold with an illegal opcode present: FETCH every cycle.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_hold%0d", i), obs_word(), W_FETCH);
    end
    reset = 1'b0;

    // Load: 0,1,2,3,4,0
    run_instr("ldr",   2'b01, 6'b011001, {4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 6);
    // Store: 0,1,2,5,0
    run_instr("str",   2'b01, 6'b011000, {8'd0, 4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 5);
    // Data-processing immediate: 0,1,7,8,0
    run_instr("addi",  2'b00, 6'b101000, {8'd0, 4'd0, 4'd8, 4'd7, 4'd1, 4'd0}, 5);
    // Data-processing register: 0,1,6,8,0
    run_instr("addr",  2'b00, 6'b001000, {8'd0, 4'd0, 4'd8, 4'd6, 4'd1, 4'd0}, 5);
    // Branch: 0,1,9,0
    run_instr("b",     2'b10, 6'b000000, {12'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 4);
    // Illegal: 0,1,10,0
    run_instr("ill",   2'b11, 6'b111111, {12'd0, 4'd0, 4'd10, 4'd1, 4'd0}, 4);
    // Funct[5] must not leak into a memory op, and L must pick the load path.
    run_instr("ldr_i", 2'b01, 6'b100001, {4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 6);

    // Reset while in MEMWR: MemW shows in that cycle only.
    Op    = 2'b01;
    Funct = 6'b000000;
    step();  // DECODE
    step();  // MEMADR
    step();  // MEMWR
    reset = 1'b1;
    check("rst_in_memwr", obs_word(), W_MEMWR);
    step();
    check("rst_after_memwr", obs_word(), W_FETCH);
    reset = 1'b0;
    step();
    check("post_rst_decode", obs_word(), W_DECODE);

    // Reset while in MEMRD cuts the load short before its MEMWB write.
    Op    = 2'b01;
    Funct = 6'b000001;
    step();  // MEMADR
    step();  // MEMRD
    check("ldr_memrd", obs_word(), W_MEMRD);
    reset = 1'b1;
    step();
    check("rst_after_memrd", obs_word(), W_FETCH);
    reset = 1'b0;
    Op = 2'b10;
    step();
    check("resume_decode", obs_word(), W_DECODE);
    step();
    check("resume_branch", obs_word(), W_BRANCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
